// File: rtl/tron_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tron_pkg
// Description : Shared game-flow types for the Tron datapath. The state
//               encoding is visible to score, renderer and bike controllers,
//               so the numeric values are fixed.
// Contents    : game_state_t - 3-bit sequencer state / Game_State encoding
//               winner_t     - 2-bit winner code (none/blue/red/draw)
//               max_int      - constant-time helper for parameter sizing
// Revision    : 1.0 - initial release
// ============================================================================
package tron_pkg;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    CLEAR     = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  // Bit 0 is blue, bit 1 is red, so a simultaneous win ORs into DRAW.
  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_BLUE = 2'b01,
    WIN_RED  = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchronizer followed by a registered rising-edge
//               detector. The pulse is one Clk wide and appears three Clk
//               cycles after the input rise is first sampled.
// Ports       : Clk      - system clock
//               Reset    - asynchronous active-high reset
//               i_async  - asynchronous level input
//               o_pulse  - one-cycle pulse on a synchronized rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic i_async,
  output logic o_pulse
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic       r_pulse;
  // Marks when r_prev holds a real post-reset sample. Without it the reset
  // value of r_prev would look like a low level, and an input held high
  // across reset release would fake a rising edge.
  logic [2:0] r_fill;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
      r_fill  <= 3'b000;
    end else begin
      r_meta  <= i_async;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_fill  <= {r_fill[1:0], 1'b1};
      r_pulse <= r_fill[2] & r_sync & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
// Module      : round_controller
// Description : Game-flow sequencer for the Tron datapath. Paces the
//               pre-round countdown and game-over hold from frame ticks,
//               runs a four-phase clear handshake between rounds and keeps
//               a sticky win latch.
// Ports       : Clk, Reset       - 50 MHz clock, async active-high reset
//               frame_clk        - ~60 Hz frame strobe (asynchronous)
//               start_key        - start key level (asynchronous)
//               reset_round      - point-scored pulse from score block
//               Blue_W, Red_W    - win pulses from score block
//               clear_done       - ack from trail-clear engine
//               Game_State       - current state (game_state_t encoding)
//               Reset_Score      - one-cycle pulse at new-game start
//               clear_req        - request to trail-clear engine
//               countdown        - display digit, 0 outside COUNTDOWN
//               winner           - winner_t code
// Revision    : 1.0 - initial release
// ============================================================================
module round_controller
  import tron_pkg::*;
#(
  parameter int COUNT_FRAMES = 60,
  parameter int COUNT_STEPS  = 3,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       reset_round,
  input  logic       Blue_W,
  input  logic       Red_W,
  input  logic       clear_done,
  output logic [2:0] Game_State,
  output logic       Reset_Score,
  output logic       clear_req,
  output logic [1:0] countdown,
  output logic [1:0] winner
);

  localparam int c_fc_max = max_int(COUNT_FRAMES, OVER_FRAMES);
  localparam int c_fc_w   = $clog2(c_fc_max + 1);

  localparam logic [c_fc_w-1:0] c_fc_sat   = c_fc_w'(c_fc_max);
  localparam logic [c_fc_w-1:0] c_fc_count = c_fc_w'(COUNT_FRAMES);
  localparam logic [c_fc_w-1:0] c_fc_over  = c_fc_w'(OVER_FRAMES);
  localparam logic [1:0]        c_cd_start = 2'(COUNT_STEPS);

  logic w_frame_tick;
  logic w_start_edge;

  sync_edge u_sync_frame (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_async (frame_clk),
    .o_pulse (w_frame_tick)
  );

  sync_edge u_sync_start (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_async (start_key),
    .o_pulse (w_start_edge)
  );

  game_state_t       r_state,     w_state_nxt;
  winner_t           r_winner,    w_winner_nxt;
  logic [1:0]        r_countdown, w_countdown_nxt;
  logic              r_clear_req, w_clear_req_nxt;
  logic              r_reset_sc,  w_reset_sc_nxt;
  logic [c_fc_w-1:0] r_frames,    w_frames_nxt;
  logic [c_fc_w-1:0] w_frames_inc;
  winner_t           w_win_latched;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= TITLE;
      r_winner    <= WIN_NONE;
      r_countdown <= 2'd0;
      r_clear_req <= 1'b0;
      r_reset_sc  <= 1'b0;
      r_frames    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_winner    <= w_winner_nxt;
      r_countdown <= w_countdown_nxt;
      r_clear_req <= w_clear_req_nxt;
      r_reset_sc  <= w_reset_sc_nxt;
      r_frames    <= w_frames_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_winner_nxt    = r_winner;
    w_countdown_nxt = r_countdown;
    w_clear_req_nxt = r_clear_req;
    w_reset_sc_nxt  = 1'b0;
    w_frames_nxt    = r_frames;

    w_frames_inc  = (r_frames == c_fc_sat) ? r_frames : r_frames + 1'b1;
    // Only the first win is captured; later pulses leave the latch alone.
    w_win_latched = (r_winner == WIN_NONE) ? winner_t'({Red_W, Blue_W}) : r_winner;

    case (r_state)
      TITLE: begin
        if (w_start_edge) begin
          w_reset_sc_nxt = 1'b1;
          w_winner_nxt   = WIN_NONE;
          w_state_nxt    = CLEAR;
        end
      end

      CLEAR: begin
        w_winner_nxt = w_win_latched;
        if (!r_clear_req) begin
          // Wait for the engine to drop its previous ack before requesting.
          if (!clear_done) w_clear_req_nxt = 1'b1;
        end else if (clear_done) begin
          w_clear_req_nxt = 1'b0;
          w_frames_nxt    = '0;
          // A win arriving in this same cycle still routes to GAME_OVER.
          if (w_win_latched != WIN_NONE) begin
            w_state_nxt = GAME_OVER;
          end else begin
            w_state_nxt     = COUNTDOWN;
            w_countdown_nxt = c_cd_start;
          end
        end
      end

      COUNTDOWN: begin
        w_winner_nxt = w_win_latched;
        if (w_frame_tick) begin
          if (w_frames_inc == c_fc_count) begin
            w_frames_nxt = '0;
            if (r_countdown <= 2'd1) begin
              w_countdown_nxt = 2'd0;
              w_state_nxt     = PLAY;
            end else begin
              w_countdown_nxt = r_countdown - 2'd1;
            end
          end else begin
            w_frames_nxt = w_frames_inc;
          end
        end
      end

      PLAY: begin
        w_winner_nxt = w_win_latched;
        if (Blue_W || Red_W) begin
          w_state_nxt  = GAME_OVER;
          w_frames_nxt = '0;
        end else if (reset_round) begin
          w_state_nxt = CLEAR;
        end
      end

      GAME_OVER: begin
        if (w_frame_tick) begin
          w_frames_nxt = w_frames_inc;
          if (w_frames_inc == c_fc_over) w_state_nxt = TITLE;
        end
      end

      default: w_state_nxt = TITLE;
    endcase
  end

  assign Game_State  = r_state;
  assign winner      = r_winner;
  assign countdown   = r_countdown;
  assign clear_req   = r_clear_req;
  assign Reset_Score = r_reset_sc;

endmodule
`default_nettype wire
